w5300_bus_ctrl: RTL and testbench
=================================

Name: w5300_bus_ctrl

Overview:
Parametrised host-side bus controller that drives the W5300 parallel register/FIFO bus (addr, cs/rd/wr strobes, data) from a simple command interface. It is the successor to the hard-coded single-byte strobe sequencing in the uart top level.
- Generalises data width (8/16), setup/strobe/hold timing and burst length.
- Adds fixed-address FIFO bursts for Sn_RX_FIFOR/Sn_TX_FIFOR and an interrupt synchroniser.
- Sits between the command/UART logic and the top-level tristate pad.

Parameters:
DATA_W, 16, bus data width in bits; legal values 8 or 16
ADDR_W, 10, W5300 address width
SETUP_CYC, 1, clocks addr/cs valid before strobe falls (>=1)
STROBE_CYC, 3, clocks rd_n/wr_n held low (>=1); 3 x 37 ns meets W5300 tRD/tWR
HOLD_CYC, 1, clocks addr/cs/data held after strobe rises (>=1)
LEN_W, 8, width of burst length field; max burst is 2^LEN_W beats

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_fixed  in  1  1 = address held constant (FIFO register), 0 = increment by DATA_W/8 per beat
cmd_addr  in  ADDR_W  start address
cmd_len  in  LEN_W  beats minus one
wr_data  in  DATA_W  write beat data
wr_valid  in  1  write data available
wr_ready  out  1  one-cycle pulse when the current wr_data is consumed
rd_data  out  DATA_W  read beat data
rd_valid  out  1  one-cycle pulse per read beat
done  out  1  one-cycle pulse after the last beat's hold completes
bus_addr  out  ADDR_W  W5300 address
bus_data_o  out  DATA_W  write data to pad
bus_data_oe  out  1  pad output enable
bus_data_i  in  DATA_W  read data from pad
bus_cs_n  out  1  chip select, active low
bus_rd_n  out  1  read strobe, active low
bus_wr_n  out  1  write strobe, active low
int_n  in  1  W5300 /INT, asynchronous
irq  out  1  synchronised, active-high interrupt level

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: bus_cs_n = bus_rd_n = bus_wr_n = 1; bus_data_oe = 0; bus_addr = 0; bus_data_o = 0; rd_data = 0; rd_valid = wr_ready = done = 0; irq = 0; FSM = IDLE; all counters = 0.
- Reset asserted mid-transfer: strobes and cs_n go high and oe goes low asynchronously, with no glitch to a low level. The pending command is discarded.
- FSM states: IDLE, WAIT_WD, SETUP, STROBE, HOLD, DONE.
- IDLE: cmd_ready = 1. On cmd_valid, latch cmd_wr/cmd_fixed/cmd_addr/cmd_len and set beat counter = cmd_len. Go to WAIT_WD if cmd_wr, otherwise SETUP.
- WAIT_WD: bus_cs_n = 1. When wr_valid = 1, capture wr_data into bus_data_o, pulse wr_ready, and go to SETUP.
- SETUP: bus_cs_n = 0 and bus_addr valid; bus_data_oe = cmd_wr. Lasts SETUP_CYC clocks.
- STROBE: bus_rd_n or bus_wr_n = 0 for exactly STROBE_CYC clocks.
  - Read: on the last STROBE clock, register bus_data_i into rd_data and pulse rd_valid on the following clock.
- HOLD: strobe = 1; cs_n, addr and data unchanged for HOLD_CYC clocks. Then:
  - If beat counter = 0, go to DONE.
  - Otherwise decrement the counter, advance the address (unless cmd_fixed), and go to SETUP (read) or WAIT_WD (write).
- DONE: bus_cs_n = 1, bus_data_oe = 0, done = 1 for one clock, then IDLE.
- Address arithmetic: increment wraps modulo 2^ADDR_W with no error. When DATA_W = 16 the address LSB is forced to 0.
- Beat timing: per read beat = SETUP_CYC + STROBE_CYC + HOLD_CYC clocks. Consecutive read beats keep cs_n low; only the strobe toggles.
- Command handling: cmd_valid outside IDLE is ignored, since cmd_ready = 0.
- Interrupt path: irq = NOT int_n through a 2-flop synchroniser; latency 2 clocks, independent of the FSM.

Optional Feature:
W5300_TURNAROUND_EN:
- Defined: insert one TURN state after every HOLD that is not followed by DONE. TURN drives bus_cs_n = 1 and bus_data_oe = 0 for 1 clock, so each beat costs one extra clock.
- Undefined: no TURN state; cs_n stays low across beats.

Test Plan:
Read 0x201, len 0, bus returns 0x0002 -> bus_rd_n low exactly 3 clocks, bus_addr = 0x200 (LSB forced to 0), rd_data = 0x0002 with a single rd_valid pulse, done one clock after HOLD, cmd_ready back high.
Fixed read 0x230, len 4, bus returns 0x0100..0x0104 -> 5 rd_valid pulses in order, bus_addr constant 0x230, cs_n low continuously, 25 clocks from SETUP to DONE.
Incrementing write 0x010, len 2, data 0xAAAA/0x5555/0x1234, wr_valid low for 4 clocks before beat 2 -> addresses 0x010/0x012/0x014, cs_n high during the stall, oe high only in SETUP..HOLD, 3 wr_ready pulses.
rst_n low during the 2nd STROBE clock of a write -> strobes/cs_n high and oe low immediately; after release, IDLE with cmd_ready = 1 and no done pulse.
int_n low for 1 clock then high -> irq high for 1 clock, 2 clocks later; held low -> irq stays high.
W5300_TURNAROUND_EN defined, fixed read len 1 -> exactly one clock of cs_n = 1 between the beats, total 11 clocks.

Source files
------------

// File: rtl/w5300_bus_ctrl_if.sv
// w5300_bus_ctrl_if: command, write/read data and W5300 pad signals of the bus controller.
//   master : controller side (drives strobes, address, pad data, handshakes, irq)
//   slave  : environment side (command source, write data source, pad read data, /INT)
interface w5300_bus_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic              cmd_fixed;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data_o;
    logic              bus_data_oe;
    logic [DATA_W-1:0] bus_data_i;
    logic              bus_cs_n;
    logic              bus_rd_n;
    logic              bus_wr_n;
    logic              int_n;
    logic              irq;

    modport master (
        input  cmd_valid, cmd_wr, cmd_fixed, cmd_addr, cmd_len, wr_data, wr_valid, bus_data_i, int_n,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, bus_addr, bus_data_o, bus_data_oe,
               bus_cs_n, bus_rd_n, bus_wr_n, irq
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_fixed, cmd_addr, cmd_len, wr_data, wr_valid, bus_data_i, int_n,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, bus_addr, bus_data_o, bus_data_oe,
               bus_cs_n, bus_rd_n, bus_wr_n, irq
    );
endinterface

// File: rtl/w5300_bus_ctrl.sv
// w5300_bus_ctrl: W5300 parallel bus master with timed setup/strobe/hold, bursts and /INT sync.
//   clk, rst_n (async active-low); b: w5300_bus_ctrl_if.master carrying the command port
//   (cmd_*), write data (wr_data/wr_valid/wr_ready), read data (rd_data/rd_valid), done,
//   the W5300 pad (bus_addr, bus_data_o/oe/i, bus_cs_n, bus_rd_n, bus_wr_n), int_n and irq.
//   Optional: define W5300_TURNAROUND_EN to release cs_n/oe for one clock between beats.
module w5300_bus_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int LEN_W      = 8
) (
    input logic                clk,
    input logic                rst_n,
    w5300_bus_ctrl_if.master   b
);
    localparam int CMAX = (SETUP_CYC > STROBE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                   : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [ADDR_W-1:0] AMASK = (DATA_W == 16) ? ~ADDR_W'(1) : '1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {IDLE, WAIT_WD, SETUP, STROBE, HOLD, DONE, TURN} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [LEN_W-1:0]  beats;
    logic              wr_q;
    logic              fixed_q;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] rd_data_r;
    logic              oe, cs_n, rd_n, wr_n;
    logic              rd_valid_r, wr_ready_r, done_r;
    logic              irq_s1, irq_r;

    assign b.cmd_ready   = state == IDLE;
    assign b.bus_addr    = addr_r;
    assign b.bus_data_o  = data_o;
    assign b.bus_data_oe = oe;
    assign b.bus_cs_n    = cs_n;
    assign b.bus_rd_n    = rd_n;
    assign b.bus_wr_n    = wr_n;
    assign b.rd_data     = rd_data_r;
    assign b.rd_valid    = rd_valid_r;
    assign b.wr_ready    = wr_ready_r;
    assign b.done        = done_r;
    assign b.irq         = irq_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1 <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            irq_s1 <= ~b.int_n;
            irq_r  <= irq_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            beats      <= '0;
            wr_q       <= 1'b0;
            fixed_q    <= 1'b0;
            addr_r     <= '0;
            data_o     <= '0;
            rd_data_r  <= '0;
            oe         <= 1'b0;
            cs_n       <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            rd_valid_r <= 1'b0;
            wr_ready_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            wr_ready_r <= 1'b0;
            done_r     <= 1'b0;
            case (state)
                IDLE: if (b.cmd_valid) begin
                    wr_q    <= b.cmd_wr;
                    fixed_q <= b.cmd_fixed;
                    addr_r  <= b.cmd_addr & AMASK;
                    beats   <= b.cmd_len;
                    cnt     <= '0;
                    state   <= b.cmd_wr ? WAIT_WD : SETUP;
                    cs_n    <= b.cmd_wr;
                end
                WAIT_WD: if (b.wr_valid) begin
                    data_o     <= b.wr_data;
                    wr_ready_r <= 1'b1;
                    cs_n       <= 1'b0;
                    oe         <= 1'b1;
                    state      <= SETUP;
                end
                SETUP: if (cnt == CW'(SETUP_CYC - 1)) begin
                    cnt   <= '0;
                    state <= STROBE;
                    rd_n  <= wr_q;
                    wr_n  <= ~wr_q;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                STROBE: if (cnt == CW'(STROBE_CYC - 1)) begin
                    cnt   <= '0;
                    state <= HOLD;
                    rd_n  <= 1'b1;
                    wr_n  <= 1'b1;
                    if (!wr_q) begin
                        rd_data_r  <= b.bus_data_i;
                        rd_valid_r <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HOLD: if (cnt == CW'(HOLD_CYC - 1)) begin
                    cnt <= '0;
                    if (beats == '0) begin
                        state  <= DONE;
                        cs_n   <= 1'b1;
                        oe     <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        beats <= beats - 1'b1;
                        if (!fixed_q)
                            addr_r <= (addr_r + STEP) & AMASK;
                        oe <= 1'b0;
`ifdef W5300_TURNAROUND_EN
                        state <= TURN;
                        cs_n  <= 1'b1;
`else
                        // reads keep cs_n low across beats; writes release it while waiting for data
                        state <= wr_q ? WAIT_WD : SETUP;
                        cs_n  <= wr_q;
`endif
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                TURN: begin
                    state <= wr_q ? WAIT_WD : SETUP;
                    cs_n  <= wr_q;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_w5300_bus_ctrl.sv
// tb_w5300_bus_ctrl: directed checks of reads, fixed/incrementing bursts, write stalls, reset and irq.
module tb_w5300_bus_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    w5300_bus_ctrl_if #(.DATA_W(16), .ADDR_W(10), .LEN_W(8)) b();

    w5300_bus_ctrl #(
        .DATA_W(16), .ADDR_W(10), .SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1), .LEN_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .b(b)
    );

`ifdef W5300_TURNAROUND_EN
    localparam int TURN = 1;
`else
    localparam int TURN = 0;
`endif

    int n_tot = 0;
    int n_bad = 0;

    int rd_low, wr_low, n_str, rv, wr_idx, stall, dcnt, done_k, first_cs;
    int oe_cnt, oe_bad, cs_hi_mid, busy_rdy;
    logic        prev_strb;
    logic [15:0] rd_base;
    logic [15:0] wdat [3];
    logic [9:0]  addr_log [8];
    logic [15:0] dat_log [8];
    logic [15:0] rdat_log [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input logic wr, input logic fixed, input logic [9:0] addr,
                       input logic [7:0] len, input int ncyc);
        rd_low = 0; wr_low = 0; n_str = 0; rv = 0; wr_idx = 0; stall = 0; dcnt = 0;
        done_k = -1; first_cs = -1; oe_cnt = 0; oe_bad = 0; cs_hi_mid = 0; busy_rdy = 0;
        prev_strb = 1'b1;
        b.cmd_wr = wr; b.cmd_fixed = fixed; b.cmd_addr = addr; b.cmd_len = len;
        b.cmd_valid = 1'b1;
        b.bus_data_i = rd_base;
        b.wr_data = wdat[0];
        b.wr_valid = wr;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            b.cmd_valid = 1'b0;
            if (!b.bus_cs_n && first_cs < 0) first_cs = k;
            if (!b.bus_rd_n) rd_low++;
            if (!b.bus_wr_n) wr_low++;
            if ((!b.bus_rd_n || !b.bus_wr_n) && prev_strb && n_str < 8) begin
                addr_log[n_str] = b.bus_addr;
                dat_log[n_str] = b.bus_data_o;
                n_str++;
            end
            prev_strb = b.bus_rd_n & b.bus_wr_n;
            if (b.rd_valid) begin
                if (rv < 8) rdat_log[rv] = b.rd_data;
                rv++;
                b.bus_data_i = rd_base + 16'(rv);
            end
            if (b.wr_ready) begin
                wr_idx++;
                if (wr_idx < 3) b.wr_data = wdat[wr_idx];
            end
            if (b.done) begin
                dcnt++;
                done_k = k;
            end
            if (b.bus_data_oe) oe_cnt++;
            if (b.bus_data_oe && b.bus_cs_n) oe_bad++;
            if (first_cs >= 0 && done_k < 0 && b.bus_cs_n) cs_hi_mid++;
            if (first_cs >= 0 && done_k < 0 && b.cmd_ready) busy_rdy++;
            if (wr && wr_idx == 1 && b.bus_cs_n && stall < 4 && first_cs >= 0 && done_k < 0) begin
                b.wr_valid = 1'b0;
                stall++;
            end else begin
                b.wr_valid = wr && wr_idx <= int'(len);
            end
        end
        b.wr_valid = 1'b0;
    endtask

    initial begin
        b.cmd_valid = 1'b0; b.cmd_wr = 1'b0; b.cmd_fixed = 1'b0; b.cmd_addr = '0; b.cmd_len = '0;
        b.wr_data = '0; b.wr_valid = 1'b0; b.bus_data_i = '0; b.int_n = 1'b1;
        wdat[0] = 16'hAAAA; wdat[1] = 16'h5555; wdat[2] = 16'h1234;
        rd_base = '0;
        repeat (2) @(negedge clk);
        chk("rst_cs_n", 32'(b.bus_cs_n), 1);
        chk("rst_rd_n", 32'(b.bus_rd_n), 1);
        chk("rst_wr_n", 32'(b.bus_wr_n), 1);
        chk("rst_oe", 32'(b.bus_data_oe), 0);
        chk("rst_addr", 32'(b.bus_addr), 0);
        chk("rst_data_o", 32'(b.bus_data_o), 0);
        chk("rst_rd_data", 32'(b.rd_data), 0);
        chk("rst_strobes", {29'd0, b.rd_valid, b.wr_ready, b.done}, 0);
        chk("rst_irq", 32'(b.irq), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(b.cmd_ready), 1);

        rd_base = 16'h0002;
        run(1'b0, 1'b0, 10'h201, 8'd0, 8);
        chk("r0_rd_low", 32'(rd_low), 3);
        chk("r0_addr", 32'(addr_log[0]), 32'h200);
        chk("r0_rv", 32'(rv), 1);
        chk("r0_rdata", 32'(rdat_log[0]), 32'h0002);
        chk("r0_done_k", 32'(done_k), 5);
        chk("r0_done_cnt", 32'(dcnt), 1);
        chk("r0_busy_rdy", 32'(busy_rdy), 0);
        chk("r0_ready_end", 32'(b.cmd_ready), 1);

        rd_base = 16'h0100;
        run(1'b0, 1'b1, 10'h230, 8'd4, 40);
        chk("fr_rv", 32'(rv), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fr_rdata%0d", i), 32'(rdat_log[i]), 32'h100 + 32'(i));
            chk($sformatf("fr_addr%0d", i), 32'(addr_log[i]), 32'h230);
        end
        chk("fr_rd_low", 32'(rd_low), 15);
        chk("fr_span", 32'(done_k - first_cs), 32'(25 + 4 * TURN));
        chk("fr_cs_hi", 32'(cs_hi_mid), 32'(4 * TURN));
        chk("fr_done_cnt", 32'(dcnt), 1);

        rd_base = 16'h0300;
        run(1'b0, 1'b1, 10'h230, 8'd1, 20);
        chk("f1_span", 32'(done_k - first_cs), 32'(10 + TURN));
        chk("f1_cs_hi", 32'(cs_hi_mid), 32'(TURN));
        chk("f1_rdata1", 32'(rdat_log[1]), 32'h0301);

        run(1'b0, 1'b0, 10'h3FE, 8'd1, 20);
        chk("wrap_addr0", 32'(addr_log[0]), 32'h3FE);
        chk("wrap_addr1", 32'(addr_log[1]), 32'h000);

        run(1'b1, 1'b0, 10'h010, 8'd2, 35);
        chk("w_wr_ready", 32'(wr_idx), 3);
        chk("w_addr0", 32'(addr_log[0]), 32'h010);
        chk("w_addr1", 32'(addr_log[1]), 32'h012);
        chk("w_addr2", 32'(addr_log[2]), 32'h014);
        chk("w_data0", 32'(dat_log[0]), 32'hAAAA);
        chk("w_data1", 32'(dat_log[1]), 32'h5555);
        chk("w_data2", 32'(dat_log[2]), 32'h1234);
        chk("w_wr_low", 32'(wr_low), 9);
        chk("w_oe_cnt", 32'(oe_cnt), 15);
        chk("w_oe_bad", 32'(oe_bad), 0);
        chk("w_first_cs", 32'(first_cs), 1);
        chk("w_cs_hi", 32'(cs_hi_mid), 32'(6 + TURN));
        chk("w_done_k", 32'(done_k), 32'(22 + TURN));

        b.cmd_wr = 1'b1; b.cmd_fixed = 1'b0; b.cmd_addr = 10'h040; b.cmd_len = 8'd0;
        b.cmd_valid = 1'b1; b.wr_data = 16'h7777; b.wr_valid = 1'b1;
        @(negedge clk);
        b.cmd_valid = 1'b0;
        @(negedge clk);
        b.wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rs_pre_wr_n", 32'(b.bus_wr_n), 0);
        rst_n = 1'b0;
        #1;
        chk("rs_wr_n", 32'(b.bus_wr_n), 1);
        chk("rs_cs_n", 32'(b.bus_cs_n), 1);
        chk("rs_oe", 32'(b.bus_data_oe), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b.done) dcnt++;
        end
        chk("rs_no_done", 32'(dcnt), 0);
        chk("rs_ready", 32'(b.cmd_ready), 1);

        b.int_n = 1'b0;
        @(negedge clk);
        chk("irq_lat1", 32'(b.irq), 0);
        b.int_n = 1'b1;
        @(negedge clk);
        chk("irq_pulse", 32'(b.irq), 1);
        @(negedge clk);
        chk("irq_clear", 32'(b.irq), 0);
        b.int_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("irq_hold_a", 32'(b.irq), 1);
        repeat (5) @(negedge clk);
        chk("irq_hold_b", 32'(b.irq), 1);
        b.int_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("irq_release", 32'(b.irq), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
